alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the 8-function combinational ALU.
- Registers every operation behind a valid/ready handshake.
- Adds iterative unsigned multiply, divide and remainder, plus arithmetic shift right.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mc_iter.sv | 86 ++++++++
 rtl/alu_mc.sv | 152 +++++++++++++++
 tb/tb_alu_mc.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, FSM states and helpers.
package alu_pkg;

  localparam int FUNCT_W = 4;

  typedef enum logic [FUNCT_W-1:0] {
    F_SUM  = 4'd0,
    F_SHL  = 4'd1,
    F_SUB  = 4'd2,
    F_LOAD = 4'd3,
    F_XOR  = 4'd4,
    F_SHR  = 4'd5,
    F_NOT  = 4'd6,
    F_AND  = 4'd7,
    F_MUL  = 4'd8,
    F_DIVU = 4'd9,
    F_REMU = 4'd10,
    F_SRA  = 4'd11
  } alu_funct_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  // Operations that run through the iterative datapath.
  function automatic logic is_iter(input logic [FUNCT_W-1:0] f);
    return (f == F_MUL) || (f == F_DIVU) || (f == F_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: shift-add multiply (one multiplier bit per cycle) and
// restoring division (one quotient bit per cycle), SIZE steps per operation.
// The result outputs show the value of the step being taken this cycle, so
// they are the final answer during the cycle that done is high.
module alu_mc_iter #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,        // 0: multiply, 1: divide
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            done,
  output logic [SIZE-1:0] product,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder
);

  localparam int CW = $clog2(SIZE);

  // x: multiplier / dividend-then-quotient; y: multiplicand / divisor;
  // z: product accumulator / partial remainder.
  logic            busy_q;
  logic            op_q;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] x_q, y_q, z_q;
  logic [SIZE-1:0] x_n, y_n, z_n;
  logic [SIZE:0]   tmp;
  logic [SIZE-1:0] diff;

  // One iteration step of whichever operation is loaded.
  always_comb begin
    tmp  = {z_q, x_q[SIZE-1]};
    diff = tmp[SIZE-1:0] - y_q;
    x_n  = x_q;
    y_n  = y_q;
    z_n  = z_q;
    if (op_q) begin
      // With a zero divisor every trial subtract succeeds: quotient all ones,
      // remainder ends up holding the dividend.
      if (tmp >= {1'b0, y_q}) begin
        z_n = diff;
        x_n = {x_q[SIZE-2:0], 1'b1};
      end else begin
        z_n = tmp[SIZE-1:0];
        x_n = {x_q[SIZE-2:0], 1'b0};
      end
    end else begin
      if (x_q[0]) z_n = z_q + y_q;
      y_n = y_q << 1;
      x_n = x_q >> 1;
    end
  end

  // Operand load on start, then SIZE steps counted down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      op_q   <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      op_q   <= op;
      cnt_q  <= CW'(SIZE - 1);
      x_q    <= op ? a : b;
      y_q    <= op ? b : a;
      z_q    <= '0;
    end else if (busy_q) begin
      x_q <= x_n;
      y_q <= y_n;
      z_q <= z_n;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign done      = busy_q && (cnt_q == '0);
  assign product   = z_n;
  assign quotient  = x_n;
  assign remainder = z_n;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage.
// Handshake: a request is taken on a rising edge with in_valid & in_ready;
// a result is handed over on a rising edge with out_valid & out_ready, and
// result/flags/out_valid hold steady until then.
module alu_mc
  import alu_pkg::*;
#(
  parameter int SIZE = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [SIZE-1:0]    a,
  input  logic [SIZE-1:0]    b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIZE-1:0]    result,
  output logic               overflow,
  output logic               negative,
  output logic               zero,
  output logic               equal,
  output logic               greater,
  output logic               less,
  output logic               div_by_zero,
  output logic [1:0]         dbg_state
);

  localparam int SHW = $clog2(SIZE);

  alu_state_e         state_q, state_d;
  logic               accept, load, iter_op, iter_done;
  logic [FUNCT_W-1:0] funct_q, f_s;
  logic [SIZE-1:0]    a_q, b_q, x_s, y_s;
  logic [SIZE-1:0]    product, quotient, remainder, res_c;
  logic [SHW-1:0]     sh;
  logic               ovf_c, dbz_c;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign dbg_state = state_q;
  assign iter_op   = (funct != F_MUL);
  assign load      = (accept && !is_iter(funct)) || (state_q == S_BUSY && iter_done);

  alu_mc_iter #(.SIZE(SIZE)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_iter(funct)),
    .op        (iter_op),
    .a         (a),
    .b         (b),
    .done      (iter_done),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Operand source: live inputs when accepting, captured copies afterwards.
  always_comb begin
    f_s = funct_q;
    x_s = a_q;
    y_s = b_q;
    if (state_q == S_IDLE) begin
      f_s = funct;
      x_s = a;
      y_s = b;
    end
  end

  // Result mux and overflow / divide-by-zero flags.
  always_comb begin
    sh    = y_s[SHW-1:0];
    res_c = '0;
    case (f_s)
      F_SUM:  res_c = x_s + y_s;
      F_SHL:  res_c = x_s << sh;
      F_SUB:  res_c = x_s - y_s;
      F_LOAD: res_c = x_s;
      F_XOR:  res_c = x_s ^ y_s;
      F_SHR:  res_c = x_s >> sh;
      F_NOT:  res_c = ~x_s;
      F_AND:  res_c = x_s & y_s;
      F_MUL:  res_c = product;
      F_DIVU: res_c = quotient;
      F_REMU: res_c = remainder;
      F_SRA:  res_c = $signed(x_s) >>> sh;
      default: res_c = '0;
    endcase
    ovf_c = 1'b0;
    if (f_s == F_SUM)
      ovf_c = (x_s[SIZE-1] == y_s[SIZE-1]) && (res_c[SIZE-1] != x_s[SIZE-1]);
    else if (f_s == F_SUB)
      ovf_c = (x_s[SIZE-1] != y_s[SIZE-1]) && (res_c[SIZE-1] != x_s[SIZE-1]);
    dbz_c = ((f_s == F_DIVU) || (f_s == F_REMU)) && (y_s == '0);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_iter(funct) ? S_BUSY : S_DONE;
      S_BUSY: if (iter_done) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Operand capture on accept so later input changes cannot disturb the op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (accept) begin
      funct_q <= funct;
      a_q     <= a;
      b_q     <= b;
    end
  end

  // Result and status flags, registered together when the op completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result      <= '0;
      overflow    <= 1'b0;
      negative    <= 1'b0;
      zero        <= 1'b0;
      equal       <= 1'b0;
      greater     <= 1'b0;
      less        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      result      <= res_c;
      overflow    <= ovf_c;
      negative    <= res_c[SIZE-1];
      zero        <= (res_c == '0);
      equal       <= (x_s == y_s);
      greater     <= ($signed(x_s) > $signed(y_s));
      less        <= ($signed(x_s) < $signed(y_s));
      div_by_zero <= dbz_c;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed cases with literal expectations plus randomized
// traffic, all checked against an arithmetic model of each operation.
module tb_alu_mc;

  localparam int SIZE = 64;
  localparam int SHW  = $clog2(SIZE);
  localparam int W    = SIZE + 7;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      funct = '0;
  logic [SIZE-1:0] a = '0;
  logic [SIZE-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [SIZE-1:0] result;
  logic            overflow, negative, zero, equal, greater, less, div_by_zero;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  alu_mc #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .negative(negative), .zero(zero),
    .equal(equal), .greater(greater), .less(less), .div_by_zero(div_by_zero),
    .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packs {result, overflow, negative, zero, equal, greater, less, div_by_zero}.
  function automatic logic [W-1:0] model(input logic [3:0] f, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
    logic [SIZE-1:0] r;
    logic [SHW-1:0]  s;
    logic            ov, dz;
    s  = y[SHW-1:0];
    ov = 1'b0;
    dz = 1'b0;
    case (f)
      4'd0:  r = x + y;
      4'd1:  r = x << s;
      4'd2:  r = x - y;
      4'd3:  r = x;
      4'd4:  r = x ^ y;
      4'd5:  r = x >> s;
      4'd6:  r = ~x;
      4'd7:  r = x & y;
      4'd8:  r = x * y;
      4'd9:  begin r = (y == 0) ? '1 : x / y; dz = (y == 0); end
      4'd10: begin r = (y == 0) ? x : x % y;  dz = (y == 0); end
      4'd11: r = $signed(x) >>> s;
      default: r = '0;
    endcase
    if (f == 4'd0) ov = (x[SIZE-1] == y[SIZE-1]) && (r[SIZE-1] != x[SIZE-1]);
    if (f == 4'd2) ov = (x[SIZE-1] != y[SIZE-1]) && (r[SIZE-1] != x[SIZE-1]);
    return {r, ov, r[SIZE-1], (r == 0), (x == y),
            ($signed(x) > $signed(y)), ($signed(x) < $signed(y)), dz};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0]    exp_q[$];
  int              acc_q[$];
  int              lat_q[$];
  logic [W-1:0]    cur;
  bit              have_cur = 0;
  bit              fire_pend = 0;
  logic [SIZE-1:0] last_res = '0;
  logic [6:0]      last_flags = '0;

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    if (reset) begin
      have_cur  = 0;
      fire_pend = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {overflow, negative, zero, equal, greater, less, div_by_zero}, 0);
    end else begin
      if (fire_pend) begin
        have_cur  = 0;
        fire_pend = 0;
      end
      if (out_valid && !have_cur) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: got result %0h with no op pending", result);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1;
          chk("latency", ncyc - acc_q.pop_front(), lat_q.pop_front());
        end
      end
      if (have_cur) begin
        chk("out_valid_hold", out_valid, 1);
        chk("result", result, cur[W-1:7]);
        chk("flags", {overflow, negative, zero, equal, greater, less, div_by_zero}, cur[6:0]);
        chk("in_ready_done", in_ready, 0);
        last_res   = result;
        last_flags = {overflow, negative, zero, equal, greater, less, div_by_zero};
        if (out_ready) fire_pend = 1;
      end else begin
        chk("in_ready", in_ready, exp_q.size() == 0);
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = stalled, 2 = random.
  int or_mode = 0;
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] f, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
    int acc;
    bit ok;
    ok       = 0;
    acc      = 0;
    in_valid = 1'b1;
    funct    = f;
    a        = x;
    b        = y;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok  = 1;
        acc = ncyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stuck low, state %0d", dbg_state);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    funct    = 4'($urandom());
    a        = {$urandom(), $urandom()};
    b        = {$urandom(), $urandom()};
    exp_q.push_back(model(f, x, y));
    acc_q.push_back(acc);
    lat_q.push_back((f == 4'd8 || f == 4'd9 || f == 4'd10) ? SIZE + 1 : 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !have_cur) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d ops outstanding, state %0d", exp_q.size(), dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SIZE-1:0] rand_op();
    case ($urandom_range(0, 4))
      0, 1: return {$urandom(), $urandom()};
      2:    return SIZE'($urandom_range(0, 20));
      3:    return '0;
      default: begin
        case ($urandom_range(0, 2))
          0:       return {1'b0, {(SIZE-1){1'b1}}};
          1:       return {1'b1, {(SIZE-1){1'b0}}};
          default: return '1;
        endcase
      end
    endcase
  endfunction

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // SUM overflow into the sign bit.
    send(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    wait_idle();
    chk("sum_lit_res", last_res, 64'h8000_0000_0000_0000);
    chk("sum_lit_flags", last_flags, 7'b1100100);

    // Arithmetic vs logical shift right, shift amount from low bits of b.
    send(4'd11, 64'hF000_0000_0000_0000, 64'h44);
    wait_idle();
    chk("sra_lit_res", last_res, 64'hFF00_0000_0000_0000);
    send(4'd5, 64'hF000_0000_0000_0000, 64'h44);
    wait_idle();
    chk("shr_lit_res", last_res, 64'h0F00_0000_0000_0000);

    // Multiply, 65-cycle latency checked by the compare process.
    send(4'd8, 64'd123456789, 64'd987654321);
    wait_idle();
    chk("mul_lit_res", last_res, 64'd121932631112635269);

    // Division, remainder, and the divide-by-zero cases.
    send(4'd9, 64'd100, 64'd7);
    wait_idle();
    chk("divu_lit_res", last_res, 64'd14);
    send(4'd10, 64'd100, 64'd7);
    wait_idle();
    chk("remu_lit_res", last_res, 64'd2);
    send(4'd9, 64'd5, 64'd0);
    wait_idle();
    chk("divu0_lit_res", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divu0_lit_flags", last_flags, 7'b0100101);
    send(4'd10, 64'd5, 64'd0);
    wait_idle();
    chk("remu0_lit_res", last_res, 64'd5);
    chk("remu0_lit_flags", last_flags, 7'b0000101);

    // Backpressure: result held for 10 cycles while a request waits outside.
    or_mode = 1;
    @(posedge clk);
    #1;
    send(4'd4, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F);
    in_valid = 1'b1;
    funct    = 4'd0;
    a        = 64'd1;
    b        = 64'd2;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    or_mode  = 0;
    wait_idle();
    chk("xor_lit_res", last_res, 64'h1D3B_5977_95B3_D1FF);

    // Reset 20 cycles into a divide, then a SUB after release.
    send(4'd9, 64'd1000, 64'd3);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    send(4'd2, 64'd5, 64'd9);
    wait_idle();
    chk("sub_lit_res", last_res, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sub_lit_flags", last_flags, 7'b0100010);

    // Randomized traffic with random backpressure and idle gaps.
    or_mode = 2;
    for (int n = 0; n < 250; n++) begin
      send(4'($urandom_range(0, 15)), rand_op(), rand_op());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    or_mode = 0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
